fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream_if.sv | 24 ++
 rtl/fifo_rd_stream.sv | 99 +++++++++
 tb/tb_fifo_rd_stream.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus output stream; master = fifo_rd_stream, slave = FIFO/consumer side.
// Latency and backpressure behaviour are owned by fifo_rd_stream; this file only groups the wires.
// Stream side is valid/ready: m_data/m_valid hold while m_ready is low.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  en;
  logic                  empty;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_enb;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    input  en, empty, rd_data, m_ready,
    output rd_enb, m_data, m_valid
  );

  modport slave (
    output en, empty, rd_data, m_ready,
    input  rd_enb, m_data, m_valid
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Converts a 1-cycle-latency FIFO read port into a valid/ready stream through a 2-entry skid buffer.
// Latency: word visible on m_valid/m_data one cycle after the FIFO returns it (rd_enb + 2 edges).
// Backpressure: credit check on rd_enb keeps buffered + in-flight words <= 2; output holds while m_ready=0.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8
) (
  input  logic             rd_clk,
  input  logic             rstn,
  fifo_rd_stream_if.master bus,
  output logic [15:0]      word_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]            count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic [15:0]           word_cnt_q, word_cnt_d;
  logic                  run_q;
  logic                  pop;
  logic                  rd_enb;
  logic [1:0]            credit_used;

  assign pop         = (count_q != 2'd0) && bus.m_ready;
  assign credit_used = count_q + {1'b0, inflight_q} - {1'b0, pop};
  // run_q holds off reads until the first edge after reset release
  assign rd_enb      = run_q && bus.en && !bus.empty && (credit_used < 2'd2);

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = rd_enb;
    word_cnt_d = word_cnt_q + 16'(pop);
    case ({inflight_q, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = bus.rd_data;
        else                 tail_d = bus.rd_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = bus.rd_data;
        end else begin
          head_d = tail_q;
          tail_d = bus.rd_data;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_enb) state_d = RUN;
      RUN: begin
        if (count_d == 2'd2)                    state_d = STALL;
        else if (count_d == 2'd0 && !inflight_d) state_d = IDLE;
      end
      STALL:   if (pop) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      word_cnt_q <= 16'd0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      word_cnt_q <= word_cnt_d;
      run_q      <= 1'b1;
    end
  end

  assign bus.rd_enb  = rd_enb;
  assign bus.m_valid = (count_q != 2'd0);
  assign bus.m_data  = head_q;
  assign word_cnt    = word_cnt_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboarded bench: FIFO pushes enqueue expected words, a negedge monitor checks every stream transfer.
module tb_fifo_rd_stream;

  logic        rd_clk = 1'b0;
  logic        rstn   = 1'b1;
  logic [15:0] word_cnt;
  logic        busy;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream_if #(.DATA_WIDTH(8)) bus ();

  fifo_rd_stream #(.DATA_WIDTH(8)) dut (
    .rd_clk   (rd_clk),
    .rstn     (rstn),
    .bus      (bus),
    .word_cnt (word_cnt),
    .busy     (busy)
  );

  int         checks = 0;
  int         errors = 0;
  int         enb_cnt = 0;
  int         exp_wc = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // FIFO model: read data appears the cycle after rd_enb; reset drops its contents
  logic [7:0] mem [0:1023];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  assign bus.empty = (wr_ptr == rd_ptr);

  always @(posedge rd_clk) begin
    if (!rstn) begin
      rd_ptr <= wr_ptr;
    end else if (bus.rd_enb) begin
      bus.rd_data <= mem[rd_ptr[9:0]];
      rd_ptr      <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [7:0] d);
    mem[wr_ptr[9:0]] = d;
    wr_ptr++;
    exp_q.push_back(d);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input bit need_q_empty);
    int k = 0;
    while ((busy || (need_q_empty && exp_q.size() != 0)) && k < 400) begin
      cyc(1);
      k++;
    end
    check(name, 32'(k < 400), 32'd1);
  endtask

  // Monitor: transfer happens at the next posedge when valid && ready at negedge
  logic       hold_chk = 1'b0;
  logic [7:0] held;

  always @(negedge rd_clk) begin
    if (rstn) begin
      check("no_underflow", 32'(bus.rd_enb && bus.empty), 32'd0);
      if (bus.rd_enb) enb_cnt++;
      if (hold_chk) begin
        check("hold_valid", 32'(bus.m_valid), 32'd1);
        check("hold_data", 32'(bus.m_data), 32'(held));
      end
      hold_chk = bus.m_valid && !bus.m_ready;
      held     = bus.m_data;
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(bus.m_data), 32'hDEAD);
        end else begin
          check("stream_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
        end
      end
    end else begin
      hold_chk = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int snap;
    int bulk;
    bus.en      = 1'b1;
    bus.m_ready = 1'b1;

    // reset with a non-empty FIFO and en high
    #1 rstn = 1'b0;
    push(8'h5A);
    #2;
    check("rst_rd_enb", 32'(bus.rd_enb), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_data", 32'(bus.m_data), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    cyc(2);
    exp_q.delete();

    // single word: first read only after the first edge following release
    push(8'hA5);
    rstn = 1'b1;
    #1;
    check("no_read_at_release", 32'(bus.rd_enb), 32'd0);
    cyc(1);
    check("first_rd_enb", 32'(bus.rd_enb), 32'd1);
    cyc(1);
    check("inflight_no_read", 32'(bus.rd_enb), 32'd0);
    cyc(1);
    check("single_valid", 32'(bus.m_valid), 32'd1);
    check("single_data", 32'(bus.m_data), 32'hA5);
    wait_idle("single_drain", 1'b1);
    exp_wc = 1;
    check("single_word_cnt", 32'(word_cnt), 32'(exp_wc));
    check("single_busy", 32'(busy), 32'd0);

    // back-pressure: only two words fetched, head held
    bus.m_ready = 1'b0;
    snap = enb_cnt;
    for (int i = 1; i <= 4; i++) push(8'(i));
    cyc(8);
    check("bp_reads", 32'(enb_cnt - snap), 32'd2);
    check("bp_valid", 32'(bus.m_valid), 32'd1);
    check("bp_head", 32'(bus.m_data), 32'h01);
    check("bp_busy", 32'(busy), 32'd1);
    bus.m_ready = 1'b1;
    wait_idle("bp_drain", 1'b1);
    exp_wc += 4;
    check("bp_word_cnt", 32'(word_cnt), 32'(exp_wc));

    // streaming: 20 words back to back
    for (int i = 0; i < 20; i++) push(8'(8'h40 + i));
    begin
      int k = 0;
      while (!bus.m_valid && k < 10) begin
        cyc(1);
        k++;
      end
      check("stream_start", 32'(k), 32'd2);
    end
    for (int i = 0; i < 19; i++) begin
      cyc(1);
      check("stream_rate", 32'(bus.m_valid), 32'd1);
    end
    cyc(1);
    check("stream_end", 32'(bus.m_valid), 32'd0);
    wait_idle("stream_drain", 1'b1);
    exp_wc += 20;
    check("stream_word_cnt", 32'(word_cnt), 32'(exp_wc));

    // enable drop right after one read: the in-flight word still arrives
    snap = enb_cnt;
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    #1;
    check("drop_first_read", 32'(bus.rd_enb), 32'd1);
    cyc(1);
    bus.en = 1'b0;
    #1;
    check("drop_no_read", 32'(bus.rd_enb), 32'd0);
    check("drop_busy", 32'(busy), 32'd1);
    wait_idle("drop_drain", 1'b0);
    check("drop_reads", 32'(enb_cnt - snap), 32'd1);
    check("drop_left", 32'(exp_q.size()), 32'd3);
    check("drop_idle", 32'(busy), 32'd0);
    check("drop_word_cnt", 32'(word_cnt), 32'(exp_wc + 1));
    bus.en = 1'b1;
    wait_idle("drop_resume", 1'b1);
    exp_wc += 4;
    check("resume_word_cnt", 32'(word_cnt), 32'(exp_wc));

    // bring word_cnt to 0xFFFF, then one more transfer wraps it
    bulk = 65535 - exp_wc;
    for (int i = 0; i < bulk; i++) begin
      push(8'(i));
      cyc(1);
    end
    wait_idle("bulk_drain", 1'b1);
    check("wc_ffff", 32'(word_cnt), 32'hFFFF);
    push(8'hC3);
    wait_idle("wrap_drain", 1'b1);
    check("wc_wrap", 32'(word_cnt), 32'h0000);

    // reset with two buffered words: output drops at once, words are lost
    bus.m_ready = 1'b0;
    push(8'hD1);
    push(8'hD2);
    push(8'hD3);
    cyc(6);
    check("pre_rst_valid", 32'(bus.m_valid), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.m_valid), 32'd0);
    check("mid_rst_data", 32'(bus.m_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rd_enb", 32'(bus.rd_enb), 32'd0);
    exp_q.delete();
    cyc(2);
    bus.m_ready = 1'b1;
    rstn = 1'b1;
    cyc(6);
    check("post_rst_valid", 32'(bus.m_valid), 32'd0);
    check("post_rst_word_cnt", 32'(word_cnt), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
